// File: rtl/mlt3_rx_deser.sv
// MLT-3 receive deserializer: decodes line levels to bits, checks transition legality,
// hunts for a sync byte and delivers payload bytes MSB-first over valid/ready.
module mlt3_rx_deser #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           line,
  input  logic                 sym_en,
  input  logic                 byte_ready,
  input  logic                 clr,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  output logic                 locked,
  output logic                 sym_err,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [1:0]  LVL_ZERO = 2'b00;
  localparam logic [1:0]  LVL_NEG  = 2'b11;
  localparam logic [1:0]  LVL_BAD  = 2'b10;

  typedef enum logic {ST_HUNT, ST_LOCKED} state_e;

  state_e               state_q, state_d;
  logic [1:0]           prev_level_q, prev_level_d;
  logic [1:0]           last_nz_q, last_nz_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    byte_data_q, byte_data_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 sym_err_q, sym_err_d;
  logic                 overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic              illegal_c;
  logic              bit_c;
  logic              sym_good_c;
  logic              sym_bad_c;
  logic              byte_done_c;
  logic [BYTE_W-1:0] shift_nxt_c;

  // Transition legality and bit recovery from the current and previous level
  always_comb begin
    illegal_c = 1'b0;
    bit_c     = 1'b0;
    if (line == LVL_BAD) begin
      illegal_c = 1'b1;
    end else if (line == prev_level_q) begin
      bit_c = 1'b0;
    end else if (prev_level_q == LVL_ZERO) begin
      // leaving zero must alternate polarity against the last nonzero level
      if (line == last_nz_q) illegal_c = 1'b1;
      else                   bit_c     = 1'b1;
    end else if (line != LVL_ZERO) begin
      illegal_c = 1'b1;
    end else begin
      bit_c = 1'b1;
    end
  end

  assign sym_good_c  = sym_en & ~illegal_c;
  assign sym_bad_c   = sym_en & illegal_c;
  assign shift_nxt_c = {shift_q[BYTE_W-2:0], bit_c};

  // Next-state: line tracking, framing FSM, output handshake and status
  always_comb begin
    state_d      = state_q;
    prev_level_d = prev_level_q;
    last_nz_d    = last_nz_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    overflow_d   = overflow_q;
    err_cnt_d    = err_cnt_q;
    sym_err_d    = sym_bad_c;
    byte_done_c  = 1'b0;

    if (sym_bad_c) begin
      prev_level_d = LVL_ZERO;
    end else if (sym_good_c) begin
      prev_level_d = line;
      if (line != LVL_ZERO) last_nz_d = line;
    end

    unique case (state_q)
      ST_HUNT: begin
        if (sym_good_c) begin
          shift_d = shift_nxt_c;
          if (shift_nxt_c == SYNC_WORD) begin
            state_d   = ST_LOCKED;
            bit_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (sym_bad_c) begin
          state_d   = ST_HUNT;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else if (sym_good_c) begin
          shift_d     = shift_nxt_c;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          byte_done_c = (bit_cnt_q == CNT_W'(BYTE_W - 1));
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (byte_valid_q && byte_ready) byte_valid_d = 1'b0;
    if (clr) begin
      overflow_d = 1'b0;
      err_cnt_d  = '0;
    end

    // a completed byte loads only if the output register is free this cycle
    if (byte_done_c) begin
      if (!byte_valid_q || byte_ready) begin
        byte_data_d  = shift_nxt_c;
        byte_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (sym_bad_c) begin
      if (clr)                  err_cnt_d = ERR_CNT_W'(1);
      else if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      prev_level_q <= LVL_ZERO;
      last_nz_q    <= LVL_NEG;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      sym_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_level_q <= prev_level_d;
      last_nz_q    <= last_nz_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      sym_err_q    <= sym_err_d;
      overflow_q   <= overflow_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign locked     = (state_q == ST_LOCKED);
  assign sym_err    = sym_err_q;
  assign overflow   = overflow_q;
  assign err_cnt    = err_cnt_q;

endmodule
